gerenciador_atributos: RTL
==========================

// Module: gerenciador_atributos
// PURPOSE
//  Parametrised successor of the pet-attribute controller: N saturating attribute channels updated on a prescaled tick.
//  Driven by the one-hot pet state from the main FSM; feeds the display/HUD and the FSM's death detection.
//  Adds pause, a frozen MORTO state, per-channel target-state mapping and a starvation (death) timer.
// PARAMETERS
//  N_ATRIB      3                      number of attribute channels (0=fome, 1=sono, 2=felicidade)
//  W            8                      attribute width in bits
//  MAX_VAL      100                    saturation ceiling, < 2**W
//  INIT_VAL     {8'd50,8'd70,8'd80}    flat N_ATRIB*W init values, channel 0 in LSBs
//  ESTADO_ALVO  {DANDO_AULA,DORMINDO,COMENDO}  flat N_ATRIB*5; state that raises channel i
//  TICK_DIV     8388608                clk cycles per update tick, >= 2
//  VEL_SUBIDA   3                      increment per tick on the target channel
//  VEL_DESCIDA  1                      decrement per tick on all other channels
//  LIMIAR_CRIT  20                     critical-alert threshold
//  TICKS_MORTE  16                     consecutive ticks with any channel at 0 that trigger morte
// PORTS
//  clk        in   1           system clock
//  reset      in   1           synchronous, active-high reset
//  estado     in   5           one-hot pet state (INTRO=0, IDLE, DORMINDO, COMENDO, DANDO_AULA, MORTO)
//  pausa      in   1           1 = freeze prescaler (no ticks); attributes hold
//  atributos  out  N_ATRIB*W   registered attribute values, channel i at [i*W +: W]
//  tick       out  1           one-cycle pulse, the cycle the update is applied
//  critico    out  N_ATRIB     per-channel alert (see CONFIGURATION)
//  morte      out  1           sticky starvation flag to the main FSM
// BEHAVIOUR
//  Clock: one clock (clk); reset is synchronous and active-high (reset).
//  Reset: cnt=0, atributos=INIT_VAL, tick=0, critico=0, zero-counter=0, morte=0.
//  Prescaler: cnt counts 0..TICK_DIV-1 and wraps; tick=1 on the cycle cnt==TICK_DIV-1, else 0.
//  pausa=1: cnt holds, tick=0; releasing pausa resumes from the held count.
//  estado==INTRO (every cycle, independent of tick): atributos<=INIT_VAL, zero-counter<=0, morte<=0.
//  estado==MORTO: atributos, zero-counter and morte hold; cnt and tick keep running.
//  Any other state, on tick, per channel i:
//   estado==ESTADO_ALVO[i]: a <= min(a+VEL_SUBIDA, MAX_VAL); sum computed in W+1 bits, no wrap.
//   else: a <= (a > VEL_DESCIDA) ? a-VEL_DESCIDA : 0; never underflows.
//  Unknown or multi-hot estado: treated as IDLE (all channels decrement).
//  Death timer, on a non-MORTO, non-INTRO tick: evaluated on post-update values.
//   If any channel == 0: zero-counter += 1, saturating at TICKS_MORTE.
//   Otherwise: zero-counter <= 0.
//   morte <= 1 once the zero-counter reaches TICKS_MORTE, in the same cycle.
//   morte stays set until reset or INTRO.
//  Latency: the attribute change is visible the cycle after tick=1.
//  Simultaneous reset and INTRO: reset wins; the outcome is identical.
// CONFIGURATION
//  ATRIB_ALERTA_EN defined: critico[i] is registered and equals (a_i < LIMIAR_CRIT), updated every cycle.
//  ATRIB_ALERTA_EN undefined: critico is tied to 0; no comparators are synthesised.
// STRUCTURE
//  Package tamagotchi_pkg: one-hot state localparams (INTRO..MORTO), the state width (5), and default MAX/INIT values.
//  Sub-module canal_atributo (×N_ATRIB, generate loop):
//   one W-bit register with the saturating inc/dec next-value logic;
//   inputs: sobe, desce, carrega, init;
//   output: valor and the zero flag.
//  The top level holds the prescaler, the state decode, the death timer and the alert logic.
// TESTING (TICK_DIV=4, default values unless stated)
//  1. Reset, then estado=IDLE for 4 ticks -> tick every 4th cycle; fome 80->76, sono 70->66, felicidade 50->46.
//  2. estado=COMENDO, fome=98 -> after 1 tick fome=100 (no 101); next tick still 100; others drop by 1.
//  3. estado=IDLE, felicidade=1 -> after 1 tick = 0; further ticks hold 0 (no 255 wrap).
//  4. Force felicidade=0 in IDLE -> morte=1 exactly on the 16th tick; raising felicidade earlier via
//     DANDO_AULA clears the counter (morte stays 0).
//  5. pausa=1 for 20 cycles -> no tick, attributes hold. MORTO -> values frozen while tick pulses.
//     INTRO -> INIT_VAL next cycle and morte=0.
//  6. ATRIB_ALERTA_EN defined, sono falls 21->20->19 -> critico[1] rises when sono=19.
//     With the macro undefined, critico stays 0 throughout.

Source files
------------

// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the pet attribute manager: one-hot pet states, default channel values
// and the decode helpers used to classify the pet state each cycle.
package tamagotchi_pkg;

  localparam int W_ESTADO = 5;

  // INTRO is the all-zero code; every other state owns one bit.
  localparam logic [W_ESTADO-1:0] INTRO      = 5'b00000;
  localparam logic [W_ESTADO-1:0] IDLE       = 5'b00001;
  localparam logic [W_ESTADO-1:0] DORMINDO   = 5'b00010;
  localparam logic [W_ESTADO-1:0] COMENDO    = 5'b00100;
  localparam logic [W_ESTADO-1:0] DANDO_AULA = 5'b01000;
  localparam logic [W_ESTADO-1:0] MORTO      = 5'b10000;

  localparam int N_ATRIB_PADRAO = 3;
  localparam int W_PADRAO       = 8;
  localparam int MAX_VAL_PADRAO = 100;
  localparam logic [N_ATRIB_PADRAO*W_PADRAO-1:0] INIT_VAL_PADRAO = {8'd50, 8'd70, 8'd80};
  localparam logic [N_ATRIB_PADRAO*W_ESTADO-1:0] ESTADO_ALVO_PADRAO =
    {DANDO_AULA, DORMINDO, COMENDO};

  typedef enum logic [1:0] {
    MODO_CARGA   = 2'd0,
    MODO_CONGELA = 2'd1,
    MODO_ATIVO   = 2'd2
  } modo_t;

  function automatic modo_t decodifica_modo(input logic [W_ESTADO-1:0] e);
    if (e == INTRO) return MODO_CARGA;
    else if (e == MORTO) return MODO_CONGELA;
    else return MODO_ATIVO;
  endfunction

  // Any code that is not exactly one-hot behaves like IDLE.
  function automatic logic [W_ESTADO-1:0] estado_efetivo(input logic [W_ESTADO-1:0] e);
    int n;
    n = 0;
    for (int k = 0; k < W_ESTADO; k++) n = n + int'(e[k]);
    return (n == 1) ? e : IDLE;
  endfunction

endpackage

// File: rtl/canal_atributo.sv
// One saturating attribute channel: load, increment-with-ceiling, decrement-with-floor.
// With ATRIB_ALERTA_EN defined, the next value is also exported for the alert comparators.
module canal_atributo #(
  parameter int W           = 8,
  parameter int MAX_VAL     = 100,
  parameter int VEL_SUBIDA  = 3,
  parameter int VEL_DESCIDA = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sobe,
  input  logic         desce,
  input  logic         carrega,
  input  logic [W-1:0] init,
`ifdef ATRIB_ALERTA_EN
  output logic [W-1:0] valor_prox,
`endif
  output logic [W-1:0] valor,
  output logic         zero
);

  logic [W-1:0] valor_q, valor_d;
  logic [W:0]   soma;

  // The sum is one bit wider so the ceiling compare never sees a wrapped value.
  always_comb begin
    soma    = {1'b0, valor_q} + (W+1)'(VEL_SUBIDA);
    valor_d = valor_q;
    if (carrega) begin
      valor_d = init;
    end else if (sobe) begin
      valor_d = (soma > (W+1)'(MAX_VAL)) ? W'(MAX_VAL) : soma[W-1:0];
    end else if (desce) begin
      valor_d = (valor_q > W'(VEL_DESCIDA)) ? (valor_q - W'(VEL_DESCIDA)) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) valor_q <= init;
    else       valor_q <= valor_d;
  end

  assign valor = valor_q;
  // Zero flag refers to the post-update value so the death timer sees this tick's result.
  assign zero  = (valor_d == '0);
`ifdef ATRIB_ALERTA_EN
  assign valor_prox = valor_d;
`endif

endmodule

// File: rtl/gerenciador_atributos.sv
// Pet attribute manager: prescaled update tick, N saturating channels, starvation timer and
// optional per-channel low-value alerts (enabled by defining ATRIB_ALERTA_EN).
module gerenciador_atributos
  import tamagotchi_pkg::*;
#(
  parameter int N_ATRIB = N_ATRIB_PADRAO,
  parameter int W       = W_PADRAO,
  parameter int MAX_VAL = MAX_VAL_PADRAO,
  parameter logic [N_ATRIB*W-1:0]        INIT_VAL    = INIT_VAL_PADRAO,
  parameter logic [N_ATRIB*W_ESTADO-1:0] ESTADO_ALVO = ESTADO_ALVO_PADRAO,
  parameter int TICK_DIV    = 8388608,
  parameter int VEL_SUBIDA  = 3,
  parameter int VEL_DESCIDA = 1,
  parameter int LIMIAR_CRIT = 20,
  parameter int TICKS_MORTE = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [W_ESTADO-1:0]    estado,
  input  logic                   pausa,
  output logic [N_ATRIB*W-1:0]   atributos,
  output logic                   tick,
  output logic [N_ATRIB-1:0]     critico,
  output logic                   morte
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int ZC_W  = $clog2(TICKS_MORTE + 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ZC_W-1:0]     zc_q, zc_d;
  logic                morte_q, morte_d;
  logic                tick_w;
  modo_t               modo;
  logic [W_ESTADO-1:0] estado_ef;
  logic                carrega;
  logic [N_ATRIB-1:0]  sobe, desce, zeros;

  always_comb begin
    tick_w = !pausa && (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d  = cnt_q;
    if (!pausa) cnt_d = tick_w ? '0 : (cnt_q + CNT_W'(1));
  end

  always_comb begin
    modo      = decodifica_modo(estado);
    estado_ef = estado_efetivo(estado);
    carrega   = (modo == MODO_CARGA);
    sobe      = '0;
    desce     = '0;
    for (int i = 0; i < N_ATRIB; i++) begin
      if (modo == MODO_ATIVO && tick_w) begin
        if (estado_ef == ESTADO_ALVO[i*W_ESTADO +: W_ESTADO]) sobe[i] = 1'b1;
        else                                                 desce[i] = 1'b1;
      end
    end
  end

  // Consecutive ticks with some channel at zero; saturates so morte can be judged on equality.
  always_comb begin
    zc_d    = zc_q;
    morte_d = morte_q;
    unique case (modo)
      MODO_CARGA: begin
        zc_d    = '0;
        morte_d = 1'b0;
      end
      MODO_ATIVO: begin
        if (tick_w) begin
          if (|zeros) zc_d = (zc_q == ZC_W'(TICKS_MORTE)) ? zc_q : (zc_q + ZC_W'(1));
          else        zc_d = '0;
          morte_d = morte_q || (zc_d == ZC_W'(TICKS_MORTE));
        end
      end
      default: begin
        zc_d    = zc_q;
        morte_d = morte_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      zc_q    <= '0;
      morte_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      zc_q    <= zc_d;
      morte_q <= morte_d;
    end
  end

`ifdef ATRIB_ALERTA_EN
  logic [W-1:0]       valor_prox [N_ATRIB];
  logic [N_ATRIB-1:0] critico_q, critico_d;
`endif

  for (genvar i = 0; i < N_ATRIB; i++) begin : g_canal
    canal_atributo #(
      .W           (W),
      .MAX_VAL     (MAX_VAL),
      .VEL_SUBIDA  (VEL_SUBIDA),
      .VEL_DESCIDA (VEL_DESCIDA)
    ) u_canal (
      .clk        (clk),
      .reset      (reset),
      .sobe       (sobe[i]),
      .desce      (desce[i]),
      .carrega    (carrega),
      .init       (INIT_VAL[i*W +: W]),
`ifdef ATRIB_ALERTA_EN
      .valor_prox (valor_prox[i]),
`endif
      .valor      (atributos[i*W +: W]),
      .zero       (zeros[i])
    );
  end

`ifdef ATRIB_ALERTA_EN
  // Compared against the next value so the registered alert lines up with atributos.
  always_comb begin
    critico_d = '0;
    for (int i = 0; i < N_ATRIB; i++) critico_d[i] = (valor_prox[i] < W'(LIMIAR_CRIT));
  end

  always_ff @(posedge clk) begin
    if (reset) critico_q <= '0;
    else       critico_q <= critico_d;
  end

  assign critico = critico_q;
`else
  assign critico = '0;
`endif

  assign tick  = tick_w;
  assign morte = morte_q;

endmodule
